alu: RTL and testbench
======================

# alu

32-bit integer ALU for the RV32I single-cycle datapath, located between the register file/immediate mux and the writeback/branch logic. It computes add, subtract, logical and set-less-than operations selected by a 3-bit `ALUControl` code. Results and status flags are available combinationally in the same cycle; a registered copy is also provided for debug and pipelining.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is required.
- `clk` input 1: the single clock; rising-edge active.
- `rst_n` input 1: synchronous, active-low reset.
- `a` input WIDTH: operand A (rs1 or PC).
- `b` input WIDTH: operand B (rs2 or immediate).
- `ALUControl` input 3: operation select.
- `rslt` output WIDTH: combinational result.
- `zero` output 1: combinational, `rslt == 0`.
- `neg` output 1: combinational, `rslt[WIDTH-1]`.
- `carry` output 1: combinational carry-out of the adder. Valid for add/sub/slt/sltu; 0 otherwise.
- `ovf` output 1: combinational signed overflow of the adder. Valid for add/sub/slt/sltu; 0 otherwise.
- `rslt_q` output WIDTH: `rslt` registered on `clk`.
- `zero_q` output 1: `zero` registered on `clk`.

## Operation
- ALUControl encoding:
  - 000 ADD: a + b.
  - 001 SUB: a − b, implemented as a + ~b + 1.
  - 010 AND: a & b.
  - 011 OR: a | b.
  - 100 XOR: a ^ b.
  - 101 SLT: signed a < b gives 1, else 0, zero-extended. Computed as `sub_sign ^ ovf` on the subtract path.
  - 110 SLTU: unsigned a < b gives 1, else 0. Computed as NOT carry on the subtract path.
  - 111 reserved: `rslt` = 0, so `zero` = 1.
- A single shared adder is used. B is inverted and carry-in is set to 1 for codes 001, 101 and 110.
- Arithmetic wraps modulo 2^32; no exceptions or traps.
- Carry for SUB follows RISC convention: carry = 1 means no borrow.
- `ovf` = (a_sign == b_eff_sign) && (sum_sign != a_sign).
- `zero` is derived from the final `rslt` for every op, not only SUB. For example, AND of F0F0F0F0 and 0F0F0F0F gives `zero` = 1.
- Outputs must be free of X whenever inputs are known. There are no latches; every branch of the case statement assigns every output.

## Timing
- `rslt`, `zero`, `neg`, `carry` and `ovf` are purely combinational: zero-cycle latency, settled within the same cycle.
- `rslt_q` and `zero_q` update on every rising `clk` edge, one cycle of latency. There is no enable and no handshake.
- Reset: while `rst_n` = 0 at a rising edge, `rslt_q` is set to 0 and `zero_q` to 0.
- Reset has no effect on the combinational outputs.
- If `rst_n` deasserts mid-operation, the next edge captures the current `rslt` and `zero`.
- A change of `ALUControl` or the operands between edges affects only the combinational outputs until the next edge.

## Structure
- Shared package `alu_pkg` holds:
  - typedef enum logic [2:0] `alu_op_e` with `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_XOR`, `ALU_SLT`, `ALU_SLTU`, `ALU_RSVD`;
  - the constant `XLEN` = 32.
- The controller/decoder imports the same enum.
- One sub-module is natural: `alu_addsub`, which takes `a`, `b` and `sub` and produces `sum`, `carry` and `ovf`.
- The top level contains:
  - the operation mux (`always_comb` with `unique case`);
  - the flag logic;
  - the output register.

## Test plan
- ADD and SUB:
  - a=00004000, b=00002000, op 000 → rslt=00006000, zero=0.
  - a=0000000F, b=00000003, op 001 → rslt=0000000C, zero=0.
  - a=b=0000000A, op 001 → rslt=0, zero=1, carry=1.
- Logical:
  - AND of F0F0F0F0 and 0F0F0F0F → 0, zero=1.
  - AND of FFFFFFFF and 000000FF → 000000FF.
  - OR of F0F00000 and 0F0F0000 → FFFF0000.
  - OR of 0000FF00 and 000000FF → 0000FFFF.
  - XOR of FFFF0000 and 0F0F0F0F → F0F00F0F.
- SLT and SLTU:
  - op 101 with 3, 5 → 1.
  - op 101 with FFFFFFFF, 1 → 1.
  - op 110 with FFFFFFFF, 1 → 0.
  - op 101 with 80000000, 7FFFFFFF → 1 (overflow case).
- Overflow and wrap:
  - ADD 7FFFFFFF + 1 → 80000000, ovf=1, neg=1.
  - ADD FFFFFFFF + 1 → 0, carry=1, zero=1.
- Reserved code: op 111 → rslt=0, zero=1.
- Registered path:
  - Hold `rst_n`=0 for 2 edges → `rslt_q`=0, `zero_q`=0.
  - Release reset, apply ADD 5+3 → `rslt_q`=00000008 one edge later while `rslt` is 8 immediately.
  - Assert `rst_n`=0 mid-stream → registered outputs clear at the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and datapath width.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_RSVD = 3'b111
  } alu_op_e;

  // Operations that run the shared adder in subtract mode (invert B, carry-in 1).
  function automatic logic op_uses_sub(input alu_op_e op);
    logic res;
    case (op)
      ALU_SUB, ALU_SLT, ALU_SLTU: res = 1'b1;
      default:                    res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor: sum = a + (sub ? ~b : b) + sub, with carry-out and signed overflow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_ext_s;

  // B is inverted and carry-in raised so one adder serves add and subtract.
  assign b_eff_s   = sub ? ~b : b;
  assign sum_ext_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};

  assign sum   = sum_ext_s[WIDTH-1:0];
  // Carry = 1 on subtract means no borrow.
  assign carry = sum_ext_s[WIDTH];
  // Signed overflow: operands agree in sign but the sum does not.
  assign ovf   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_ext_s[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// RV32I ALU: combinational result and flags plus a registered copy of result and zero.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic [WIDTH-1:0] rslt,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             ovf,
  output logic [WIDTH-1:0] rslt_q,
  output logic             zero_q
);

  alu_op_e          op_s;
  logic             sub_s;
  logic [WIDTH-1:0] sum_s;
  logic             add_carry_s;
  logic             add_ovf_s;
  logic [WIDTH-1:0] rslt_s;
  logic             carry_s;
  logic             ovf_s;
  logic             slt_bit_s;
  logic             sltu_bit_s;

  assign op_s  = alu_op_e'(ALUControl);
  assign sub_s = op_uses_sub(op_s);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a     (a),
    .b     (b),
    .sub   (sub_s),
    .sum   (sum_s),
    .carry (add_carry_s),
    .ovf   (add_ovf_s)
  );

  // Signed compare corrects the difference sign by overflow; unsigned compare is a borrow.
  assign slt_bit_s  = sum_s[WIDTH-1] ^ add_ovf_s;
  assign sltu_bit_s = ~add_carry_s;

  // Operation mux; adder flags are only exposed for arithmetic/compare ops.
  always_comb begin
    rslt_s  = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    unique case (op_s)
      ALU_ADD, ALU_SUB: begin
        rslt_s  = sum_s;
        carry_s = add_carry_s;
        ovf_s   = add_ovf_s;
      end
      ALU_AND: rslt_s = a & b;
      ALU_OR:  rslt_s = a | b;
      ALU_XOR: rslt_s = a ^ b;
      ALU_SLT: begin
        rslt_s  = {{(WIDTH-1){1'b0}}, slt_bit_s};
        carry_s = add_carry_s;
        ovf_s   = add_ovf_s;
      end
      ALU_SLTU: begin
        rslt_s  = {{(WIDTH-1){1'b0}}, sltu_bit_s};
        carry_s = add_carry_s;
        ovf_s   = add_ovf_s;
      end
      default: begin
        rslt_s  = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Flags are taken from the final result so they hold for every operation.
  assign rslt  = rslt_s;
  assign zero  = (rslt_s == {WIDTH{1'b0}});
  assign neg   = rslt_s[WIDTH-1];
  assign carry = carry_s;
  assign ovf   = ovf_s;

  // Debug/pipeline register: captures result and zero every edge, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rslt_q <= {WIDTH{1'b0}};
      zero_q <= 1'b0;
    end else begin
      rslt_q <= rslt_s;
      zero_q <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: driver queues expectations, monitor compares on negedge.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  ALUControl;
  logic [31:0] rslt;
  logic        zero;
  logic        neg;
  logic        carry;
  logic        ovf;
  logic [31:0] rslt_q;
  logic        zero_q;

  alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .rslt       (rslt),
    .zero       (zero),
    .neg        (neg),
    .carry      (carry),
    .ovf        (ovf),
    .rslt_q     (rslt_q),
    .zero_q     (zero_q)
  );

  typedef struct {
    int          idx;
    logic        rst_n;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rslt;
    logic        z;
    logic        n;
    logic        c;
    logic        o;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] rslt;
    logic        z;
    logic        n;
    logic        c;
    logic        o;
  } comb_exp_t;

  typedef struct {
    int          idx;
    int          due;
    logic [31:0] rslt;
    logic        z;
  } reg_exp_t;

  vec_t      vecs[$];
  comb_exp_t cq[$];
  reg_exp_t  rq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic v(input logic r, input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                   input logic [31:0] er, input logic ez, input logic en, input logic ec, input logic eo);
    vec_t t;
    t.idx = vecs.size(); t.rst_n = r; t.op = op; t.a = va; t.b = vb;
    t.rslt = er; t.z = ez; t.n = en; t.c = ec; t.o = eo;
    vecs.push_back(t);
  endtask

  // Monitor: compare combinational outputs of the current vector and any registered result now due.
  initial begin
    forever begin
      @(negedge clk);
      while (rq.size() > 0 && rq[0].due == cyc) begin
        reg_exp_t re;
        re = rq.pop_front();
        check($sformatf("v%0d rslt_q", re.idx), rslt_q, re.rslt);
        check($sformatf("v%0d zero_q", re.idx), {31'd0, zero_q}, {31'd0, re.z});
      end
      if (cq.size() > 0) begin
        comb_exp_t ce;
        ce = cq.pop_front();
        check($sformatf("v%0d rslt", ce.idx), rslt, ce.rslt);
        check($sformatf("v%0d zero", ce.idx), {31'd0, zero}, {31'd0, ce.z});
        check($sformatf("v%0d neg", ce.idx), {31'd0, neg}, {31'd0, ce.n});
        check($sformatf("v%0d carry", ce.idx), {31'd0, carry}, {31'd0, ce.c});
        check($sformatf("v%0d ovf", ce.idx), {31'd0, ovf}, {31'd0, ce.o});
      end
    end
  end

  // Driver: apply each vector just after a rising edge and queue its expectations.
  initial begin
    rst_n = 1'b0; a = 32'd0; b = 32'd0; ALUControl = 3'b000;

    //  rst  op      a             b             rslt          z     n     c     o
    v(1'b0, 3'b000, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b0, 3'b000, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b000, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b000, 32'h00004000, 32'h00002000, 32'h00006000, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b001, 32'h0000000F, 32'h00000003, 32'h0000000C, 1'b0, 1'b0, 1'b1, 1'b0);
    v(1'b1, 3'b001, 32'h0000000A, 32'h0000000A, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    v(1'b1, 3'b010, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b010, 32'hFFFFFFFF, 32'h000000FF, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b011, 32'hF0F00000, 32'h0F0F0000, 32'hFFFF0000, 1'b0, 1'b1, 1'b0, 1'b0);
    v(1'b0, 3'b011, 32'h0000FF00, 32'h000000FF, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0, 1'b1, 1'b0, 1'b0);
    v(1'b1, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b101, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b101, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0);
    v(1'b1, 3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    v(1'b1, 3'b110, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b101, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b1);
    v(1'b1, 3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1);
    v(1'b1, 3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0);
    v(1'b1, 3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0);
    v(1'b1, 3'b000, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      comb_exp_t ce;
      reg_exp_t  re;
      @(posedge clk);
      #1;
      rst_n      = vecs[i].rst_n;
      ALUControl = vecs[i].op;
      a          = vecs[i].a;
      b          = vecs[i].b;
      ce.idx = vecs[i].idx; ce.rslt = vecs[i].rslt; ce.z = vecs[i].z;
      ce.n = vecs[i].n; ce.c = vecs[i].c; ce.o = vecs[i].o;
      cq.push_back(ce);
      re.idx = vecs[i].idx;
      re.due = cyc + 1;
      re.rslt = vecs[i].rst_n ? vecs[i].rslt : 32'd0;
      re.z    = vecs[i].rst_n ? vecs[i].z : 1'b0;
      rq.push_back(re);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (cq.size() != 0 || rq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", cq.size(), rq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
